// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-counter with an IDLE/RUN/DONE control FSM.
// Counts down on qualified ticks, stops at zero and pulses done for one cycle.
module bcd_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                abort,
  input  logic                tick_en,
  output logic [4*DIGITS-1:0] q,
  output logic                busy,
  output logic                done,
  output logic                zero
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_q;
  logic [W-1:0]   w_q_nxt;
  logic [W-1:0]   w_q_dec;
  logic [W-1:0]   w_q_clamp;
  logic           r_busy;
  logic           r_done;
  logic           w_zero;
  logic           w_one;

  assign w_zero = (r_q == '0);
  assign w_one  = (r_q == W'(1));

  // Out-of-range preset digits saturate to 9 so the counter never holds non-BCD.
  always_comb begin
    w_q_clamp = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) w_q_clamp[4*i +: 4] = 4'd9;
    end
  end

  // Borrow ripples up through zero digits; each zero digit it passes wraps to 9.
  always_comb begin
    logic borrow;
    borrow  = 1'b1;
    w_q_dec = r_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (r_q[4*i +: 4] == 4'd0) begin
          w_q_dec[4*i +: 4] = 4'd9;
        end else begin
          w_q_dec[4*i +: 4] = r_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    if (load) begin
      w_q_nxt     = w_q_clamp;
      w_state_nxt = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!abort && start) w_state_nxt = w_zero ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (abort) begin
            w_state_nxt = S_IDLE;
          end else if (w_zero) begin
            w_state_nxt = S_DONE;
          end else if (tick_en) begin
            w_q_nxt = w_q_dec;
            if (w_one) w_state_nxt = S_DONE;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign q    = r_q;
  assign busy = r_busy;
  assign done = r_done;
  assign zero = w_zero;

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Synchronous, loadable, multi-digit BCD down-counter with a run/done control FSM.
- Counts down from a loaded BCD value on qualified ticks, stops at 00, and pulses done for one cycle.
- It is the counting-down counterpart to the team's up-counting mod-10 ripple counter.
- Used as a countdown/interval timer feeding display and control logic; all state is on one clock, with no ripple-clocked flops.

Parameters:
- DIGITS, 2, number of BCD digits (1..4); counter width is 4*DIGITS.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- load  input  1  load load_val into counter (synchronous)
- load_val  input  4*DIGITS  BCD preset value, digit 0 in bits [3:0]
- start  input  1  begin countdown from current value
- abort  input  1  stop countdown, hold current value
- tick_en  input  1  decrement qualifier (e.g. 1 Hz strobe); a tick is consumed only in RUN
- q  output  4*DIGITS  current BCD count
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when count reaches zero
- zero  output  1  combinational, high when q == 0

Behaviour:
- Reset (asynchronous, dominant over everything): q=0, state=IDLE, busy=0, done=0; zero=1.
- States: IDLE, RUN, DONE. Outputs are registered except zero.
- Priority each cycle: reset > load > abort > start > tick_en.
- load, in any state:
  - q <= load_val, next state IDLE, done=0.
  - Any digit of load_val > 9 is clamped to 9 on load.
  - A start in the same cycle is ignored.
- IDLE:
  - start with q != 0 -> RUN; busy=1 from the next cycle. No decrement in the start cycle, even if tick_en=1.
  - start with q == 0 -> DONE directly, so done pulses on the next cycle.
  - tick_en is ignored in IDLE.
- RUN, cycle with tick_en=1: BCD decrement by 1.
  - Digit i decrements if all lower digits are 0.
  - Each lower digit that is 0 wraps to 9.
  - Digits never hold values above 9.
  - Example: 20 -> 19, 100 -> 099.
- RUN, terminal count: if q == 1 and tick_en=1, q becomes 0 and the next state is DONE. The counter never wraps below 0.
- RUN, abort: next state IDLE with q held. No decrement on that cycle, even if tick_en=1.
- RUN, start: ignored.
- DONE:
  - done=1 for exactly that one cycle, busy=0, q=0.
  - Unconditional return to IDLE on the next cycle.
  - A load in the DONE cycle takes effect normally, and done still shows 1 for that cycle.
- zero is combinational from q and valid in all states.
- tick_en held high continuously: one decrement per clock.
- Reset asserted mid-RUN: outputs clear immediately (asynchronously). Counting restarts only after a new load and start.

Test Plan:
- Reset/idle: assert reset with q=37 mid-RUN -> q=00, busy=0, done=0, zero=1 immediately. After release, tick_en pulses leave q=00.
- Basic countdown: load 12, start, 12 tick_en pulses -> q sequence 12,11,10,09,...,01,00. done is high exactly one cycle after 01->00, busy then drops, and zero=1.
- Digit borrow and clamp: load 100 with DIGITS=3 and one tick -> q=099. load_val 0x3C (3,12) with DIGITS=2 -> q=39.
- Abort/resume: load 05, start, 2 ticks -> 03. abort with tick_en=1 in the same cycle -> q stays 03, IDLE. start, 3 ticks -> 00, done pulse.
- Zero start: load 00, start -> done pulses once on the next cycle, busy never asserts, q=00.
- Collisions: load 40 together with start -> q=40, IDLE, busy=0. start during RUN -> no effect. load 25 during RUN -> q=25, IDLE, no done pulse.
